// File: rtl/vga_fill_engine.sv
// Rectangle fill engine: CPU-programmed rectangle streamed as raster-order pixel
// writes to the VGA Avalon pixel port, with busy/done/error status and an interrupt.
module vga_fill_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [3:0]  master_address,
    output logic        master_write,
    output logic [31:0] master_writedata,
    input  logic        master_waitrequest,
    output logic        irq
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DRAW, S_FINISH} state_t;

    state_t      state_q, state_d;
    logic [7:0]  x0_q, x0_d, x1_q, x1_d, cx_q, cx_d;
    logic [6:0]  y0_q, y0_d, y1_q, y1_d, cy_q, cy_d;
    logic [2:0]  colour_q, colour_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d, error_q, error_d;
    logic        abort_pend_q, abort_pend_d;

    logic ctrl_wr, start_req, abort_req, clr_req;
    logic accept, last_px, rect_ok, abort_now;
    logic unused_wdata;

    assign ctrl_wr      = write && (address == 4'd0);
    assign start_req    = ctrl_wr && writedata[0];
    assign abort_req    = ctrl_wr && writedata[1];
    assign clr_req      = ctrl_wr && writedata[2];
    assign accept       = (state_q == S_DRAW) && !master_waitrequest;
    assign last_px      = (cx_q == x1_q) && (cy_q == y1_q);
    assign abort_now    = abort_req || abort_pend_q;
    assign rect_ok      = (x0_q <= x1_q) && (x1_q <= 8'd159) &&
                          (y0_q <= y1_q) && (y1_q <= 7'd119);
    assign unused_wdata = ^writedata[31:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x0_q         <= '0;
            y0_q         <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            colour_q     <= '0;
            irq_en_q     <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            colour_q     <= colour_d;
            irq_en_q     <= irq_en_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_req) state_d = S_CHECK;
            S_CHECK:  state_d = (!abort_req && rect_ok) ? S_DRAW : S_IDLE;
            S_DRAW: begin
                if (accept) begin
                    if (abort_now)    state_d = S_IDLE;
                    else if (last_px) state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Configuration is frozen outside IDLE, so the colour sampled at start holds for the whole run.
    always_comb begin
        x0_d         = x0_q;
        y0_d         = y0_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        colour_d     = colour_q;
        irq_en_d     = irq_en_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        done_d       = done_q;
        error_d      = error_q;
        abort_pend_d = abort_pend_q;
        if (state_q == S_IDLE && write) begin
            case (address)
                4'd1:    x0_d     = writedata[7:0];
                4'd2:    y0_d     = writedata[6:0];
                4'd3:    x1_d     = writedata[7:0];
                4'd4:    y1_d     = writedata[6:0];
                4'd5:    colour_d = writedata[2:0];
                4'd6:    irq_en_d = writedata[0];
                default: ;
            endcase
        end
        if (clr_req) begin
            done_d  = 1'b0;
            error_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end
            S_CHECK: begin
                cx_d = x0_q;
                cy_d = y0_q;
                if (!abort_req && !rect_ok) error_d = 1'b1;
            end
            S_DRAW: begin
                if (abort_req) abort_pend_d = 1'b1;
                if (accept) begin
                    if (abort_now || last_px) begin
                        abort_pend_d = 1'b0;
                    end else if (cx_q < x1_q) begin
                        cx_d = cx_q + 8'd1;
                    end else begin
                        cx_d = x0_q;
                        cy_d = cy_q + 7'd1;
                    end
                end
            end
            S_FINISH: done_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        master_address   = 4'd0;
        master_write     = (state_q == S_DRAW);
        master_writedata = '0;
        if (state_q == S_DRAW)
            master_writedata = {13'b0, colour_q, cx_q, 1'b0, cy_q};
        irq = done_q && irq_en_q;
    end

    always_comb begin
        readdata = '0;
        if (read) begin
            case (address)
                4'd0:    readdata = {29'b0, error_q, done_q, (state_q != S_IDLE)};
                4'd1:    readdata = {24'b0, x0_q};
                4'd2:    readdata = {25'b0, y0_q};
                4'd3:    readdata = {24'b0, x1_q};
                4'd4:    readdata = {25'b0, y1_q};
                4'd5:    readdata = {29'b0, colour_q};
                4'd6:    readdata = {31'b0, irq_en_q};
                default: readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fill_engine.sv
// Bench for vga_fill_engine: directed scenarios plus randomized rectangles and stalls,
// compared against a raster-order pixel model.
module tb_vga_fill_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  master_address;
    logic        master_write;
    logic [31:0] master_writedata;
    logic        master_waitrequest;
    logic        irq;

    vga_fill_engine dut (
        .clk                (clk),
        .reset              (reset),
        .address            (address),
        .read               (read),
        .write              (write),
        .writedata          (writedata),
        .readdata           (readdata),
        .master_address     (master_address),
        .master_write       (master_write),
        .master_writedata   (master_writedata),
        .master_waitrequest (master_waitrequest),
        .irq                (irq)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail = 0;
    bit          rnd_wait = 1'b0;
    logic [31:0] got_q[$];
    int          hold_viol = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;

    // Transfer monitor: records accepted pixel words and flags any change while stalled.
    always @(negedge clk) begin
        if (prev_hold && !(master_write === 1'b1 && master_writedata === prev_data))
            hold_viol = hold_viol + 1;
        if (master_write === 1'b1 && master_waitrequest === 1'b0 && reset === 1'b0)
            got_q.push_back(master_writedata);
        prev_hold = (master_write === 1'b1) && (master_waitrequest === 1'b1) && (reset === 1'b0);
        prev_data = master_writedata;
    end

    function automatic logic [31:0] px_word(int x, int y, int c);
        return 32'(c * 65536 + x * 256 + y);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_wait) master_waitrequest = ($urandom_range(0, 2) == 0);
    endtask

    task automatic reg_wr(input int a, input logic [31:0] d);
        address   = 4'(a);
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic reg_rd(input int a, output logic [31:0] d);
        address = 4'(a);
        read    = 1'b1;
        #1;
        d       = readdata;
        read    = 1'b0;
    endtask

    task automatic setup(input int x0, input int y0, input int x1, input int y1, input int col);
        reg_wr(1, 32'(x0));
        reg_wr(2, 32'(y0));
        reg_wr(3, 32'(x1));
        reg_wr(4, 32'(y1));
        reg_wr(5, 32'(col));
    endtask

    task automatic wait_idle(input string tag, input int bound);
        logic [31:0] s;
        bit ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            reg_rd(0, s);
            if (s[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({tag, " finished"}, 32'(ok), 32'd1);
    endtask

    task automatic verify_run(input string tag, input int base, input int x0, input int y0,
                              input int x1, input int y1, input int col);
        int n = (x1 - x0 + 1) * (y1 - y0 + 1);
        int idx = base;
        int bad = 0;
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                if (idx >= got_q.size() || got_q[idx] !== px_word(x, y, col)) bad++;
                idx++;
            end
        end
        check({tag, " count"}, 32'(got_q.size() - base), 32'(n));
        check({tag, " words"}, 32'(bad), 32'd0);
    endtask

    task automatic run_rect(input string tag, input int x0, input int y0, input int x1,
                            input int y1, input int col);
        logic [31:0] s;
        int base, hv;
        setup(x0, y0, x1, y1, col);
        base = got_q.size();
        hv   = hold_viol;
        reg_wr(0, 32'h1);
        wait_idle(tag, (x1 - x0 + 1) * (y1 - y0 + 1) * 20 + 50);
        verify_run(tag, base, x0, y0, x1, y1, col);
        reg_rd(0, s);
        check({tag, " status"}, s, 32'h2);
        check({tag, " hold"}, 32'(hold_viol - hv), 32'd0);
    endtask

    initial begin
        logic [31:0] s;
        logic [31:0] exp4[4];
        int base;
        exp4 = '{32'h70101, 32'h70201, 32'h70102, 32'h70202};

        reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
        master_waitrequest = 1'b0;
        tick(); tick();
        reset = 1'b0;

        check("rst mwrite", 32'(master_write), 32'd0);
        check("rst mdata", master_writedata, 32'd0);
        check("rst irq", 32'(irq), 32'd0);
        check("rst maddr", 32'(master_address), 32'd0);
        for (int a = 0; a < 7; a++) begin
            reg_rd(a, s);
            check($sformatf("rst reg%0d", a), s, 32'd0);
        end

        // Register map, unused bits and unmapped addresses
        reg_wr(1, 32'hFFFF_FFFF); reg_rd(1, s); check("x0 bits", s, 32'hFF);
        reg_wr(2, 32'hFFFF_FFFF); reg_rd(2, s); check("y0 bits", s, 32'h7F);
        reg_wr(5, 32'hFFFF_FFFF); reg_rd(5, s); check("colour bits", s, 32'h7);
        reg_wr(6, 32'hFFFF_FFFF); reg_rd(6, s); check("irqen bits", s, 32'h1);
        check("irq no done", 32'(irq), 32'd0);
        reg_wr(9, 32'hFFFF_FFFF); reg_rd(9, s); check("addr9", s, 32'd0);
        reg_rd(15, s); check("addr15", s, 32'd0);
        reg_wr(6, 32'h0);

        // Basic 2x2 run, cycle by cycle
        setup(1, 1, 2, 2, 7);
        base = got_q.size();
        reg_wr(0, 32'h1);
        check("2x2 check cycle", 32'(master_write), 32'd0);
        reg_rd(0, s); check("2x2 busy", s, 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("2x2 mw%0d", i), 32'(master_write), 32'd1);
            check($sformatf("2x2 px%0d", i), master_writedata, exp4[i]);
        end
        tick();
        check("2x2 finish mw", 32'(master_write), 32'd0);
        tick();
        reg_rd(0, s); check("2x2 done", s, 32'h2);
        check("2x2 count", 32'(got_q.size() - base), 32'd4);

        // Same run with a 3-cycle stall on the second pixel
        base = got_q.size();
        reg_wr(0, 32'h1);
        tick(); check("stall px0", master_writedata, 32'h70101);
        tick(); check("stall px1", master_writedata, 32'h70201);
        master_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall hold%0d", i), master_writedata, 32'h70201);
            check($sformatf("stall mw%0d", i), 32'(master_write), 32'd1);
        end
        master_waitrequest = 1'b0;
        tick(); check("stall px2", master_writedata, 32'h70102);
        tick(); check("stall px3", master_writedata, 32'h70202);
        tick(); tick();
        reg_rd(0, s); check("stall done", s, 32'h2);
        verify_run("stall", base, 1, 1, 2, 2, 7);

        // Invalid rectangles
        base = got_q.size();
        setup(5, 0, 4, 0, 1);
        reg_wr(0, 32'h1);
        tick();
        reg_rd(0, s); check("bad x error", s, 32'h4);
        setup(0, 0, 4, 120, 1);
        reg_wr(0, 32'h1);
        tick();
        reg_rd(0, s); check("bad y error", s, 32'h4);
        check("bad no pixels", 32'(got_q.size() - base), 32'd0);
        reg_wr(0, 32'h4);
        reg_rd(0, s); check("error cleared", s, 32'h0);

        // Config writes and restart during a run are ignored
        setup(1, 1, 2, 2, 7);
        base = got_q.size();
        reg_wr(0, 32'h1);
        reg_wr(5, 32'h3);
        reg_wr(0, 32'h1);
        wait_idle("ignore", 50);
        verify_run("ignore", base, 1, 1, 2, 2, 7);
        reg_rd(5, s); check("ignore colour", s, 32'h7);
        repeat (5) tick();
        check("ignore single run", 32'(got_q.size() - base), 32'd4);
        reg_rd(0, s); check("ignore status", s, 32'h2);

        // Clear in the FINISH cycle loses to the done set
        setup(3, 3, 3, 3, 1);
        reg_wr(0, 32'h1);
        tick(); tick();
        reg_wr(0, 32'h4);
        reg_rd(0, s); check("clear vs finish", s, 32'h2);

        // Abort in CHECK
        setup(0, 0, 1, 0, 1);
        base = got_q.size();
        reg_wr(0, 32'h1);
        reg_wr(0, 32'h2);
        repeat (3) tick();
        reg_rd(0, s); check("abort check status", s, 32'h0);
        check("abort check pixels", 32'(got_q.size() - base), 32'd0);

        // Start plus abort in IDLE: start wins
        base = got_q.size();
        reg_wr(0, 32'h3);
        wait_idle("start wins", 50);
        verify_run("start wins", base, 0, 0, 1, 0, 1);

        // Abort mid-DRAW while stalled
        setup(0, 0, 3, 1, 2);
        base = got_q.size();
        reg_wr(0, 32'h1);
        tick(); tick();
        master_waitrequest = 1'b1;
        reg_wr(0, 32'h2);
        check("abort held mw", 32'(master_write), 32'd1);
        check("abort held px", master_writedata, px_word(1, 0, 2));
        master_waitrequest = 1'b0;
        tick();
        check("abort mw off", 32'(master_write), 32'd0);
        reg_rd(0, s); check("abort status", s, 32'h0);
        repeat (3) tick();
        check("abort count", 32'(got_q.size() - base), 32'd2);
        check("abort word0", got_q[base], px_word(0, 0, 2));
        check("abort word1", got_q[base + 1], px_word(1, 0, 2));

        // Reset mid-DRAW with the port stalled
        setup(0, 0, 9, 0, 5);
        reg_wr(6, 32'h1);
        base = got_q.size();
        reg_wr(0, 32'h1);
        tick(); tick();
        master_waitrequest = 1'b1;
        reset = 1'b1;
        tick();
        check("reset mw", 32'(master_write), 32'd0);
        check("reset mdata", master_writedata, 32'd0);
        check("reset irq", 32'(irq), 32'd0);
        reset = 1'b0;
        master_waitrequest = 1'b0;
        reg_rd(0, s); check("reset status", s, 32'h0);
        reg_rd(3, s); check("reset x1", s, 32'h0);
        reg_rd(6, s); check("reset irqen", s, 32'h0);
        repeat (3) tick();
        check("reset count", 32'(got_q.size() - base), 32'd1);

        // Random rectangles with random stalls
        rnd_wait = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int x0 = $urandom_range(0, 155);
            int y0 = $urandom_range(0, 116);
            run_rect($sformatf("rnd%0d", r), x0, y0, x0 + $urandom_range(0, 4),
                     y0 + $urandom_range(0, 3), $urandom_range(0, 7));
        end
        rnd_wait = 1'b0;
        master_waitrequest = 1'b0;

        // Full screen with interrupt
        reg_wr(6, 32'h1);
        run_rect("full", 0, 0, 159, 119, 0);
        check("full last", got_q[got_q.size() - 1], 32'h09F77);
        check("full irq", 32'(irq), 32'd1);
        repeat (3) tick();
        check("full irq held", 32'(irq), 32'd1);
        reg_wr(0, 32'h4);
        check("full irq cleared", 32'(irq), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
